// File: rtl/demux_1x4_ser.sv
// Serial 1-to-4 demultiplexer: assembles LSB-first 4-bit words per channel with
// per-channel valid/ready output handshake. Define DEMUX_PARITY_EN for 5-bit even-parity frames.
module demux_1x4_ser (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_in,
  input  logic        in_valid,
  input  logic [1:0]  select,
  output logic        in_ready,
  output logic [15:0] word_out,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready
`ifdef DEMUX_PARITY_EN
  ,
  output logic [3:0]  par_err
`endif
);

`ifdef DEMUX_PARITY_EN
  localparam int CNT_W = 3;
  localparam int SH_W  = 4;
  localparam logic [CNT_W-1:0] LAST = 3'd4;
`else
  localparam int CNT_W = 2;
  localparam int SH_W  = 3;
  localparam logic [CNT_W-1:0] LAST = 2'd3;
`endif

  logic [3:0] at_last;
  logic       accept;

  // Stall only when the incoming bit would complete a word that cannot be stored.
  always_comb begin
    in_ready = !(at_last[select] && out_valid[select] && !out_ready[select]);
    accept   = in_valid && in_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [SH_W-1:0]  shift_q, shift_d;
      logic [3:0]       word_q, word_d;
      logic             valid_q, valid_d;
      logic             take;
      logic             last;
`ifdef DEMUX_PARITY_EN
      logic             par_q, par_d;
`endif

      assign take        = accept && (select == 2'(gi));
      assign last        = take && (cnt_q == LAST);
      assign at_last[gi] = (cnt_q == LAST);

      always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = valid_q;
`ifdef DEMUX_PARITY_EN
        par_d   = par_q;
`endif
        if (valid_q && out_ready[gi]) begin
          valid_d = 1'b0;
        end
        if (last) begin
          cnt_d   = '0;
          shift_d = '0;
          valid_d = 1'b1;
`ifdef DEMUX_PARITY_EN
          word_d  = shift_q;
          par_d   = (^shift_q) ^ d_in;
`else
          word_d  = {d_in, shift_q};
`endif
        end else if (take) begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = shift_q | (SH_W'(d_in) << cnt_q);
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q   <= '0;
          shift_q <= '0;
          word_q  <= '0;
          valid_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
          par_q   <= 1'b0;
`endif
        end else begin
          cnt_q   <= cnt_d;
          shift_q <= shift_d;
          word_q  <= word_d;
          valid_q <= valid_d;
`ifdef DEMUX_PARITY_EN
          par_q   <= par_d;
`endif
        end
      end

      assign word_out[4*gi +: 4] = word_q;
      assign out_valid[gi]       = valid_q;
`ifdef DEMUX_PARITY_EN
      assign par_err[gi]         = par_q;
`endif
    end
  endgenerate

endmodule
